control_fetch: RTL
==================

# control_fetch

Sequencer that drives the fetch stage's `sel_pc` / `sel_dir` controls. It sits directly upstream of the IF stage and runs one of eight ROM-resident encrypt/decrypt algorithms once per data block, for a requested number of blocks. It reloads the algorithm's start address for every block, flags the IF/ID boundary for flush on each reload, and reports completion or a runaway-algorithm error.

## Interface
Parameters:
- `ALG_W`, 3, width of algorithm select (matches fetch `sel_dir`)
- `BLK_W`, 8, width of block count and index
- `WD_MAX`, 63, maximum cycles in RUN per block before timeout

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `start` in 1: request pulse; sampled only in IDLE
- `alg_sel` in ALG_W: algorithm to run, sampled with `start`
- `num_blocks` in BLK_W: number of blocks to process, sampled with `start`
- `end_of_alg` in 1: one-cycle pulse from decode when the algorithm's end marker is decoded
- `sel_pc` out 1: to fetch; 1 = load algorithm start address, 0 = PC+1
- `sel_dir` out ALG_W: to fetch address mux; latched algorithm
- `flush` out 1: one-cycle pulse; downstream discards in-flight instructions
- `busy` out 1: high from the cycle after accepted `start` until `done`, inclusive
- `block_idx` out BLK_W: index of the block being processed
- `done` out 1: one-cycle completion pulse
- `error` out 1: sticky timeout flag

## Operation
- FSM states: IDLE, LOAD, RUN, FINISH. All outputs are decoded from registered state or registers (Moore); no combinational input-to-output path.
- IDLE: `sel_pc`=1, which parks the PC at the start address of the latched algorithm.
  - `start`=1 and `num_blocks`≠0: latch `alg_sel` into `sel_dir` and `num_blocks` into an internal count. Set `block_idx`=0, clear `error`, go to LOAD.
  - `start`=1 and `num_blocks`=0: latch as above, clear `error`, go to FINISH. No fetch occurs.
- LOAD, one cycle: `sel_pc`=1, `flush`=1. Clear the watchdog counter and go to RUN.
- RUN: `sel_pc`=0. The watchdog counter increments each cycle.
  - `end_of_alg`=1 and `block_idx`=count−1: go to FINISH.
  - `end_of_alg`=1 otherwise: increment `block_idx` and go to LOAD.
  - Watchdog = WD_MAX with no `end_of_alg`: set `error` and go to FINISH.
  - `end_of_alg` and timeout in the same cycle: `end_of_alg` wins and `error` is not set.
- FINISH, one cycle: `done`=1, then go to IDLE. `block_idx` and `error` hold their values until the next accepted `start`.
- `start` outside IDLE is ignored. `end_of_alg` outside RUN is ignored.
- `sel_dir` is stable for the whole run; `alg_sel` changes while busy have no effect.
- Block count uses unsigned compare. `num_blocks`=255 runs 255 blocks, `block_idx` goes 0..254, and no wrap occurs.

## Timing
- Reset values: state IDLE, `sel_pc`=1, `sel_dir`=0, `flush`=0, `busy`=0, `block_idx`=0, `done`=0, `error`=0, internal count 0, watchdog 0.
- Reset in any state returns to IDLE on the next edge with the reset values; no `done` is produced.
- Latency, with `start` sampled at edge 0:
  - LOAD (`sel_pc`=1, `flush`=1) is visible in cycle 1.
  - The fetch PC holds the start address after edge 2.
  - Because the ROM is registered, the first instruction is at the fetch output after edge 3.
- Block-to-block gap: an `end_of_alg` in RUN gives LOAD in the next cycle, then RUN one cycle later.
- Run with zero blocks: `start` at edge 0 gives FINISH/`done` in cycle 1 and IDLE in cycle 2.
- Back-to-back runs: `start` is accepted on the cycle after FINISH.

## Structure
- Shared package holds:
  - State enum.
  - Algorithm select encoding: 0 enc XOR, 1 dec XOR, 2 enc shift, 3 dec shift, 4 enc circular shift, 5 dec circular shift, 6 enc add, 7 dec add.
  - Default ALG_W and BLK_W constants, shared with the fetch stage.
- Sub-module `watchdog_cnt`: 6-bit counter with synchronous clear, enable and terminal flag. Everything else stays flat.

## Test plan
- Reset mid-RUN (block 2 of 5) → next cycle IDLE, `sel_pc`=1, `busy`=0, `block_idx`=0, no `done`.
- `start`, `alg_sel`=4, `num_blocks`=3; `end_of_alg` at run-cycles 9, 9, 9 → three LOAD pulses with `flush`, `block_idx` 0→1→2, `sel_dir`=4 throughout, one `done`, `error`=0.
- `start` with `num_blocks`=0 → `done` in cycle 1, `flush` never asserted, `sel_pc` never 0.
- `num_blocks`=1 with `end_of_alg` withheld → `error`=1 and `done` exactly WD_MAX+1 cycles after entering RUN. The next `start` clears `error`.
- `end_of_alg` coincident with watchdog terminal → normal completion, `error`=0.
- `start` pulses and `alg_sel` changes during RUN → ignored; `sel_dir` unchanged and block count unaffected.

Source files
------------

// File: rtl/control_fetch_pkg.sv
// Shared definitions for the fetch control sequencer and the fetch stage:
// FSM state encoding, algorithm select encoding and default widths.
package control_fetch_pkg;

  localparam int ALG_W_DEF  = 3;
  localparam int BLK_W_DEF  = 8;
  localparam int WD_W       = 6;
  localparam int WD_MAX_DEF = 63;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Value presented on sel_dir selects the ROM start address of each algorithm.
  typedef enum logic [2:0] {
    ALG_ENC_XOR    = 3'd0,
    ALG_DEC_XOR    = 3'd1,
    ALG_ENC_SHIFT  = 3'd2,
    ALG_DEC_SHIFT  = 3'd3,
    ALG_ENC_CSHIFT = 3'd4,
    ALG_DEC_CSHIFT = 3'd5,
    ALG_ENC_ADD    = 3'd6,
    ALG_DEC_ADD    = 3'd7
  } alg_e;

endpackage

// File: rtl/control_fetch_watchdog_cnt.sv
// Per-block run-length counter: synchronous clear, count enable, and a flag
// raised while the count sits at the terminal value.
module watchdog_cnt
  import control_fetch_pkg::*;
#(
  parameter logic [WD_W-1:0] TERM = 6'd63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  // Next count: clear dominates enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WD_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == TERM);

endmodule

// File: rtl/control_fetch.sv
// Block sequencer for the fetch stage: reloads the algorithm start address and
// flushes IF/ID once per block, then reports completion or a watchdog timeout.
module control_fetch
  import control_fetch_pkg::*;
#(
  parameter int ALG_W  = ALG_W_DEF,
  parameter int BLK_W  = BLK_W_DEF,
  parameter int WD_MAX = WD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ALG_W-1:0] alg_sel,
  input  logic [BLK_W-1:0] num_blocks,
  input  logic             end_of_alg,
  output logic             sel_pc,
  output logic [ALG_W-1:0] sel_dir,
  output logic             flush,
  output logic             busy,
  output logic [BLK_W-1:0] block_idx,
  output logic             done,
  output logic             error
);

  state_e           state_q, state_d;
  logic [ALG_W-1:0] sel_dir_q, sel_dir_d;
  logic [BLK_W-1:0] count_q, count_d;
  logic [BLK_W-1:0] block_idx_q, block_idx_d;
  logic             error_q, error_d;
  logic             wd_en, wd_clr, wd_term, last_blk;

  // The watchdog only counts in RUN; holding it clear elsewhere covers the LOAD clear.
  assign wd_en    = (state_q == ST_RUN);
  assign wd_clr   = (state_q != ST_RUN);
  assign last_blk = (block_idx_q == (count_q - BLK_W'(1)));

  watchdog_cnt #(
    .TERM (WD_W'(WD_MAX))
  ) u_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .term  (wd_term)
  );

  // Next-state and register updates.
  always_comb begin
    state_d     = state_q;
    sel_dir_d   = sel_dir_q;
    count_d     = count_q;
    block_idx_d = block_idx_q;
    error_d     = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_dir_d   = alg_sel;
          count_d     = num_blocks;
          block_idx_d = '0;
          error_d     = 1'b0;
          if (num_blocks != '0) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_FINISH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // end_of_alg takes priority over a coincident timeout.
        if (end_of_alg) begin
          if (last_blk) begin
            state_d = ST_FINISH;
          end else begin
            block_idx_d = block_idx_q + BLK_W'(1);
            state_d     = ST_LOAD;
          end
        end else if (wd_term) begin
          error_d = 1'b1;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_dir_q   <= '0;
      count_q     <= '0;
      block_idx_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_dir_q   <= sel_dir_d;
      count_q     <= count_d;
      block_idx_q <= block_idx_d;
      error_q     <= error_d;
    end
  end

  assign sel_pc    = (state_q != ST_RUN);
  assign flush     = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign sel_dir   = sel_dir_q;
  assign block_idx = block_idx_q;
  assign error     = error_q;

endmodule
